// File: rtl/product_accumulator_pkg.sv
// Shared state encodings and default widths for the product accumulator.
package product_accumulator_pkg;

  typedef logic [1:0] acc_state_t;

  localparam acc_state_t ST_IDLE  = 2'd0;
  localparam acc_state_t ST_ACCUM = 2'd1;
  localparam acc_state_t ST_DONE  = 2'd2;

  localparam int DEF_PROD_WIDTH   = 4;
  localparam int DEF_ACC_WIDTH    = 12;
  localparam int DEF_NUM_PRODUCTS = 8;
  localparam int DEF_CNT_WIDTH    = 4;

endpackage

// File: rtl/product_accumulator_ripple_adder.sv
// Ripple-carry adder assembled from half_adder cells; two half adders plus
// an OR form each full-adder stage.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module ripple_adder #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] part_sum;
  logic [WIDTH-1:0] part_c0;
  logic [WIDTH-1:0] part_c1;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    half_adder u_ha0 (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (part_sum[i]),
      .carry (part_c0[i])
    );
    half_adder u_ha1 (
      .a     (part_sum[i]),
      .b     (carry[i]),
      .sum   (sum[i]),
      .carry (part_c1[i])
    );
    assign carry[i+1] = part_c0[i] | part_c1[i];
  end

  assign carry_out = carry[WIDTH];
endmodule

// File: rtl/product_accumulator.sv
// Sums a fixed number of multiplier products over valid/ready into a
// saturating accumulator and holds the total until acknowledged.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for start; last result and overflow held
//   ST_ACCUM | accepting products, prod_ready=1
//   ST_DONE  | total presented on acc_out, acc_valid=1 until ack
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_WIDTH   = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PROD_WIDTH-1:0] prod,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  acc_valid,
  input  logic                  acc_ack,
  output logic                  overflow,
  output logic                  busy
);

  acc_state_t           state;
  logic [CNT_WIDTH-1:0] count;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 xfer;
  logic                 last;

  assign prod_ext = ACC_WIDTH'(prod);

  ripple_adder #(.WIDTH(ACC_WIDTH)) u_adder (
    .a         (acc_out),
    .b         (prod_ext),
    .sum       (sum),
    .carry_out (carry)
  );

  assign prod_ready = (state == ST_ACCUM);
  assign acc_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign xfer       = prod_valid && prod_ready;
  assign last       = (count == CNT_WIDTH'(NUM_PRODUCTS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            // adder carry-out means the true sum no longer fits
            if (carry) begin
              acc_out  <= '1;
              overflow <= 1'b1;
            end else begin
              acc_out <= sum;
            end
            count <= count + CNT_WIDTH'(1);
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (acc_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 12-bit and a 6-bit instance run in
// lockstep on shared stimulus; totals are checked through a scoreboard.
module tb_product_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  prod;
  logic        prod_valid;
  logic        acc_ack;

  logic        prod_ready, acc_valid, overflow, busy;
  logic [11:0] acc_out;
  logic        prod_ready6, acc_valid6, overflow6, busy6;
  logic [5:0]  acc_out6;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    int acc12;
    bit ov12;
    int acc6;
    bit ov6;
  } exp_t;

  exp_t sb_q[$];

  int m12, m6;
  bit mo12, mo6;

  product_accumulator dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ack    (acc_ack),
    .overflow   (overflow),
    .busy       (busy)
  );

  product_accumulator #(.ACC_WIDTH(6)) dut6 (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready6),
    .acc_out    (acc_out6),
    .acc_valid  (acc_valid6),
    .acc_ack    (acc_ack),
    .overflow   (overflow6),
    .busy       (busy6)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void sat_add(inout int acc, inout bit ov, input int p, input int w);
    int lim;
    lim = (1 << w) - 1;
    if (acc + p > lim) begin
      acc = lim;
      ov  = 1'b1;
    end else begin
      acc = acc + p;
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ready"}, {prod_ready6, prod_ready}, 0);
    check_val({tag, "_valid"}, {acc_valid6, acc_valid}, 0);
    check_val({tag, "_busy"},  {busy6, busy}, 0);
  endtask

  task automatic do_run(input logic [3:0] p[8], input bit gaps, input bit start_mid,
                        input int hold_cycles, input bit start_with_ack);
    exp_t e;
    int   i;
    int   cyc;
    bit   pv;
    e.acc12 = 0; e.ov12 = 0; e.acc6 = 0; e.ov6 = 0;
    for (int k = 0; k < 8; k++) begin
      sat_add(e.acc12, e.ov12, int'(p[k]), 12);
      sat_add(e.acc6,  e.ov6,  int'(p[k]), 6);
    end
    sb_q.push_back(e);
    m12 = 0; m6 = 0; mo12 = 0; mo6 = 0;

    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!start_mid) start = 1'b0;
    check_val("start_busy", {busy6, busy}, 2'b11);
    check_val("start_acc_cleared", {acc_out6, acc_out}, 0);

    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 100) begin
      @(negedge clock);
      check_val("ready_early", {prod_ready6, prod_ready}, 2'b11);
      pv = gaps ? (cyc % 2 == 0) : 1'b1;
      prod_valid = pv;
      prod = pv ? p[i] : 4'hF;
      @(posedge clock);
      #1;
      cyc++;
      if (pv) begin
        sat_add(m12, mo12, int'(p[i]), 12);
        sat_add(m6,  mo6,  int'(p[i]), 6);
        i++;
        check_val("run_acc12", acc_out, m12);
        check_val("run_acc6",  acc_out6, m6);
        check_val("run_ovf6",  overflow6, mo6);
        if (i < 8) check_val("valid_early", {acc_valid6, acc_valid}, 0);
      end
    end
    if (i < 8) check_val("accept_timeout", i, 8);

    check_val("done_valid", {acc_valid6, acc_valid}, 2'b11);
    check_val("done_ready", {prod_ready6, prod_ready}, 0);
    if (acc_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 0, 1);
      end else begin
        e = sb_q.pop_front();
        check_val("total_acc12", acc_out, e.acc12);
        check_val("total_ovf12", overflow, e.ov12);
        check_val("total_acc6",  acc_out6, e.acc6);
        check_val("total_ovf6",  overflow6, e.ov6);
      end
    end
    start = 1'b0;

    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clock);
      prod_valid = 1'b1;
      prod = 4'h7;
      @(posedge clock);
      #1;
      check_val("hold_valid", {acc_valid6, acc_valid}, 2'b11);
      check_val("hold_ready", {prod_ready6, prod_ready}, 0);
      check_val("hold_acc12", acc_out, e.acc12);
      check_val("hold_acc6",  acc_out6, e.acc6);
    end

    @(negedge clock);
    prod_valid = 1'b0;
    acc_ack = 1'b1;
    start = start_with_ack;
    @(posedge clock);
    #1;
    acc_ack = 1'b0;
    start = 1'b0;
    check_idle_outputs("ack");
    check_val("ack_acc_held12", acc_out, e.acc12);
    check_val("ack_ovf_held6",  overflow6, e.ov6);
    repeat (2) @(posedge clock);
    #1;
    check_val("post_ack_busy", {busy6, busy}, 0);
    check_val("post_ack_acc12", acc_out, e.acc12);
  endtask

  logic [3:0] nines[8];
  logic [3:0] seq3[8];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nines = '{default: 4'h9};
    seq3  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd9, 4'd9};
    reset = 1'b1;
    start = 1'b0;
    prod = 4'h0;
    prod_valid = 1'b0;
    acc_ack = 1'b0;
    #12;
    check_idle_outputs("reset");
    check_val("reset_acc", {acc_out6, acc_out}, 0);
    check_val("reset_ovf", {overflow6, overflow}, 0);
    @(negedge clock);
    reset = 1'b0;

    // 8 x 9 back-to-back, long ack hold; 6-bit instance saturates on 8th
    do_run(nines, 1'b0, 1'b0, 20, 1'b0);

    // gapped valid, start held through ACCUM and asserted with ack
    do_run(seq3, 1'b1, 1'b1, 0, 1'b1);

    // abort a run after three accepts with an asynchronous reset
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      prod_valid = 1'b1;
      prod = 4'h9;
      @(posedge clock);
      #1;
    end
    check_val("pre_abort_acc", acc_out, 27);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    check_val("abort_acc", {acc_out6, acc_out}, 0);
    check_val("abort_ovf", {overflow6, overflow}, 0);
    @(negedge clock);
    reset = 1'b0;
    prod_valid = 1'b0;
    @(posedge clock);
    #1;
    check_val("abort_no_result", {acc_valid6, acc_valid}, 0);

    do_run(seq3, 1'b0, 1'b0, 0, 1'b0);

    check_val("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
